// File: rtl/pulse_burst_generator_pkg.sv
// Shared state encoding and config clamping for the pulse burst generator.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam int unsigned MIN_PERIOD = 2;

  function automatic logic [31:0] clamp_period(input logic [31:0] period);
    return (period < MIN_PERIOD) ? 32'(MIN_PERIOD) : period;
  endfunction

  // High time is kept in [1, P-1] so both phases last at least one cycle.
  function automatic logic [31:0] clamp_high(input logic [31:0] period,
                                             input logic [31:0] high);
    logic [31:0] p_c;
    logic [31:0] h_c;
    p_c = clamp_period(period);
    h_c = (high == 32'd0) ? 32'd1 : high;
    if (h_c >= p_c) h_c = p_c - 32'd1;
    return h_c;
  endfunction

endpackage

// File: rtl/pulse_burst_generator_if.sv
// Control, configuration and status bundle of the pulse burst generator.
interface pulse_burst_generator_if #(
  parameter int CNT_BIT_WID = 32,
  parameter int PER_BIT_WID = 16
);
  logic                   en;
  logic                   trig;
  logic [CNT_BIT_WID-1:0] cfg_num;
  logic [PER_BIT_WID-1:0] cfg_period;
  logic [PER_BIT_WID-1:0] cfg_high;
  logic                   p_out;
  logic                   busy;
  logic                   done;
  logic [CNT_BIT_WID-1:0] p_out_cnt;

  modport master (
    output en, trig, cfg_num, cfg_period, cfg_high,
    input  p_out, busy, done, p_out_cnt
  );

  modport slave (
    input  en, trig, cfg_num, cfg_period, cfg_high,
    output p_out, busy, done, p_out_cnt
  );
endinterface

// File: rtl/pulse_burst_generator_phase_timer.sv
// Loadable down-counter timing the HIGH and LOW phases; expire flags the last cycle.
module pulse_phase_timer #(
  parameter int PER_BIT_WID = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   load,
  input  logic [PER_BIT_WID-1:0] load_val,
  output logic                   expire
);
  logic [PER_BIT_WID-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = (cnt_q == PER_BIT_WID'(1));
endmodule

// File: rtl/pulse_burst_generator.sv
// Trigger-driven burst of N pulses with period P and high time H.
// Optional PULSE_BURST_RETRIG_EN: a trigger while busy restarts the burst.
module pulse_burst_generator
  import pulse_gen_pkg::*;
#(
  parameter int CNT_BIT_WID = 32,
  parameter int PER_BIT_WID = 16,
  parameter int LOOP_TYPE   = 1
) (
  input logic                    clk,
  input logic                    rstn,
  pulse_burst_generator_if.slave bus
);
  state_t                 state_q, state_d;
  logic                   p_out_q, p_out_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [CNT_BIT_WID-1:0] cnt_q, cnt_d;
  logic [CNT_BIT_WID-1:0] num_q, num_d;
  logic [PER_BIT_WID-1:0] per_q, per_d;
  logic [PER_BIT_WID-1:0] high_q, high_d;
  logic [PER_BIT_WID-1:0] per_clamp, high_clamp;
  logic                   tmr_load;
  logic [PER_BIT_WID-1:0] tmr_val;
  logic                   tmr_expire;
  logic                   launch;

  assign per_clamp  = PER_BIT_WID'(clamp_period(32'(bus.cfg_period)));
  assign high_clamp = PER_BIT_WID'(clamp_high(32'(bus.cfg_period), 32'(bus.cfg_high)));

  pulse_phase_timer #(.PER_BIT_WID(PER_BIT_WID)) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      p_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      num_q   <= '0;
      per_q   <= '0;
      high_q  <= '0;
    end else begin
      state_q <= state_d;
      p_out_q <= p_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      per_q   <= per_d;
      high_q  <= high_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    p_out_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    num_d    = num_q;
    per_d    = per_q;
    high_d   = high_q;
    tmr_load = 1'b0;
    tmr_val  = high_q;
    launch   = 1'b0;

    // In loop mode the done cycle itself is the one idle cycle before relaunch.
    if (state_q == ST_IDLE) begin
      launch = bus.en && (bus.trig || ((LOOP_TYPE != 0) && done_q));
    end else if (!bus.en) begin
      state_d = ST_IDLE;
    end
`ifdef PULSE_BURST_RETRIG_EN
    else if (bus.trig) begin
      launch = 1'b1;
    end
`endif
    else begin
      busy_d = 1'b1;
      if (state_q == ST_HIGH) begin
        if (tmr_expire) begin
          state_d  = ST_LOW;
          tmr_load = 1'b1;
          tmr_val  = per_q - high_q;
        end else begin
          p_out_d = 1'b1;
        end
      end else if (tmr_expire) begin
        if (cnt_q < num_q) begin
          state_d  = ST_HIGH;
          p_out_d  = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          tmr_load = 1'b1;
          tmr_val  = high_q;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
    end

    if (launch) begin
      num_d  = bus.cfg_num;
      per_d  = per_clamp;
      high_d = high_clamp;
      if (bus.cfg_num == '0) begin
        state_d = ST_IDLE;
        p_out_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        cnt_d   = '0;
      end else begin
        state_d  = ST_HIGH;
        p_out_d  = 1'b1;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        cnt_d    = CNT_BIT_WID'(1);
        tmr_load = 1'b1;
        tmr_val  = high_clamp;
      end
    end
  end

  assign bus.p_out     = p_out_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.p_out_cnt = cnt_q;
endmodule

// File: tb/tb_pulse_burst_generator.sv
// Directed bench: one-shot instance (LOOP_TYPE=0) and auto-repeat instance (LOOP_TYPE=1).
module tb_pulse_burst_generator;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pulse_burst_generator_if #(.CNT_BIT_WID(32), .PER_BIT_WID(16)) bus0();
  pulse_burst_generator_if #(.CNT_BIT_WID(32), .PER_BIT_WID(16)) bus1();

  pulse_burst_generator #(.CNT_BIT_WID(32), .PER_BIT_WID(16), .LOOP_TYPE(0)) dut0 (
    .clk(clk), .rstn(rstn), .bus(bus0));
  pulse_burst_generator #(.CNT_BIT_WID(32), .PER_BIT_WID(16), .LOOP_TYPE(1)) dut1 (
    .clk(clk), .rstn(rstn), .bus(bus1));

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] pm, bm, dm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Trigger dut0 and record p_out/busy/done per cycle into pm/bm/dm (bit i = i-th edge after trigger).
  // Config inputs are scrambled after the trigger; an optional second trigger is raised at retrig_at.
  task automatic run0(input logic [31:0] n, input logic [15:0] p, input logic [15:0] h,
                      input int ncyc, input int retrig_at, input logic [31:0] rn);
    bus0.cfg_num = n; bus0.cfg_period = p; bus0.cfg_high = h; bus0.trig = 1'b1;
    pm = '0; bm = '0; dm = '0;
    for (int i = 0; i < ncyc; i++) begin
      tick;
      pm[i] = bus0.p_out; bm[i] = bus0.busy; dm[i] = bus0.done;
      if (i == 0) begin
        bus0.trig = 1'b0; bus0.cfg_num = 32'd7; bus0.cfg_period = 16'd3; bus0.cfg_high = 16'd1;
      end
      if (i == retrig_at) begin
        bus0.trig = 1'b1; bus0.cfg_num = rn; bus0.cfg_period = 16'd4; bus0.cfg_high = 16'd1;
      end else if (i == retrig_at + 1) begin
        bus0.trig = 1'b0;
      end
    end
  endtask

  initial begin
    bus0.en = 1'b1; bus0.trig = 1'b0; bus0.cfg_num = '0; bus0.cfg_period = '0; bus0.cfg_high = '0;
    bus1.en = 1'b0; bus1.trig = 1'b0; bus1.cfg_num = '0; bus1.cfg_period = '0; bus1.cfg_high = '0;
    tick; tick;
    chk("rst_p_out", bus0.p_out, 0);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_done", bus0.done, 0);
    chk("rst_cnt", bus0.p_out_cnt, 0);
    rstn = 1'b1;
    tick;

    run0(32'd3, 16'd5, 16'd2, 20, -1, 0);
    chk("basic_p_out", pm, 32'hC63);
    chk("basic_busy", bm, 32'h7FFF);
    chk("basic_done", dm, 32'h8000);
    chk("basic_cnt", bus0.p_out_cnt, 3);

    run0(32'd2, 16'd1, 16'd0, 8, -1, 0);
    chk("clamp_lo_p_out", pm, 32'h5);
    chk("clamp_lo_busy", bm, 32'hF);
    chk("clamp_lo_done", dm, 32'h10);
    chk("clamp_lo_cnt", bus0.p_out_cnt, 2);

    run0(32'd2, 16'd4, 16'd7, 10, -1, 0);
    chk("clamp_hi_p_out", pm, 32'h77);
    chk("clamp_hi_busy", bm, 32'hFF);
    chk("clamp_hi_done", dm, 32'h100);

    run0(32'd0, 16'd5, 16'd2, 4, -1, 0);
    chk("zero_p_out", pm, 32'h0);
    chk("zero_busy", bm, 32'h0);
    chk("zero_done", dm, 32'h1);
    chk("zero_cnt", bus0.p_out_cnt, 0);

    run0(32'd2, 16'd4, 16'd1, 16, 1, 32'd3);
`ifdef PULSE_BURST_RETRIG_EN
    chk("retrig_p_out", pm, 32'h444);
    chk("retrig_busy", bm, 32'h3FFF);
    chk("retrig_done", dm, 32'h4000);
    chk("retrig_cnt", bus0.p_out_cnt, 3);
`else
    chk("retrig_p_out", pm, 32'h11);
    chk("retrig_busy", bm, 32'hFF);
    chk("retrig_done", dm, 32'h100);
    chk("retrig_cnt", bus0.p_out_cnt, 2);
`endif

    // Abort: en dropped right after pulse 4 rises.
    bus0.cfg_num = 32'd10; bus0.cfg_period = 16'd5; bus0.cfg_high = 16'd2; bus0.trig = 1'b1;
    tick;
    bus0.trig = 1'b0;
    for (int i = 0; i < 15; i++) tick;
    chk("abort_pre_p_out", bus0.p_out, 1);
    chk("abort_pre_cnt", bus0.p_out_cnt, 4);
    bus0.en = 1'b0;
    tick;
    chk("abort_p_out", bus0.p_out, 0);
    chk("abort_busy", bus0.busy, 0);
    chk("abort_done", bus0.done, 0);
    chk("abort_cnt", bus0.p_out_cnt, 4);
    dm = '0;
    for (int i = 0; i < 5; i++) begin
      tick;
      dm[0] = dm[0] | bus0.done;
    end
    chk("abort_no_done", dm, 0);

    bus0.trig = 1'b1;
    tick;
    bus0.trig = 1'b0;
    chk("trig_en_low_busy", bus0.busy, 0);
    chk("trig_en_low_cnt", bus0.p_out_cnt, 4);
    bus0.en = 1'b1;

    // Auto-repeat on dut1 with config held.
    bus1.cfg_num = 32'd2; bus1.cfg_period = 16'd4; bus1.cfg_high = 16'd1;
    bus1.en = 1'b1; bus1.trig = 1'b1;
    pm = '0; bm = '0; dm = '0;
    for (int i = 0; i < 27; i++) begin
      tick;
      if (i == 0) bus1.trig = 1'b0;
      pm[i] = bus1.p_out; bm[i] = bus1.busy; dm[i] = bus1.done;
    end
    chk("loop_p_out", pm, 32'h442211);
    chk("loop_busy", bm, 32'h3FDFEFF);
    chk("loop_done", dm, 32'h4020100);
    chk("loop_cnt", bus1.p_out_cnt, 2);
    bus1.en = 1'b0;
    tick;
    chk("loop_stop_busy", bus1.busy, 0);
    chk("loop_stop_p_out", bus1.p_out, 0);

    // Asynchronous reset in the middle of a HIGH phase.
    bus0.cfg_num = 32'd3; bus0.cfg_period = 16'd5; bus0.cfg_high = 16'd2; bus0.trig = 1'b1;
    tick;
    bus0.trig = 1'b0;
    chk("areset_pre_p_out", bus0.p_out, 1);
    #2 rstn = 1'b0;
    #1;
    chk("areset_p_out", bus0.p_out, 0);
    chk("areset_busy", bus0.busy, 0);
    chk("areset_cnt", bus0.p_out_cnt, 0);
    #2 rstn = 1'b1;
    tick;
    chk("areset_stays_idle", bus0.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
